// File: rtl/ll_window_unit.sv
// Per-channel sliding-window line length: running sum of |x[i]-x[i-1]| over the last WIN_LEN differences.
// Build option LL_NORM_EN: ll_out carries the window mean (sum >> LOG2_WIN) instead of the raw sum.
module ll_window_unit #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int WIN_LEN  = 16,
   parameter int LOG2_WIN = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   input  logic [CHANNELS*WIDTH-1:0]            din,
   output logic                                 out_valid,
   output logic [CHANNELS*(WIDTH+LOG2_WIN)-1:0] ll_out,
   output logic                                 win_full
);
   localparam int SUM_W = WIDTH + LOG2_WIN;
   localparam logic [LOG2_WIN:0] FILL_MAX = (LOG2_WIN+1)'(WIN_LEN);

   generate
      if (WIN_LEN < 2 || WIN_LEN != (1 << LOG2_WIN)) begin : g_bad_win
         $error("ll_window_unit: WIN_LEN must be a power of two >= 2 equal to 2**LOG2_WIN");
      end
   endgenerate

   logic [WIDTH-1:0]    prev    [CHANNELS];
   logic                primed;
   logic                s1_valid;
   logic [WIDTH-1:0]    mag_q   [CHANNELS];
   logic [WIDTH-1:0]    win_buf [CHANNELS][WIN_LEN];
   logic [SUM_W-1:0]    sum     [CHANNELS];
   logic [LOG2_WIN-1:0] wptr;
   logic [LOG2_WIN:0]   fill;
   logic [LOG2_WIN:0]   fill_next;
   logic                s2_valid;

   logic signed [WIDTH:0] diff [CHANNELS];
   logic [WIDTH-1:0]      mag  [CHANNELS];

   // Difference taken at WIDTH+1 bits so the magnitude (at most 2^WIDTH-1) fits in WIDTH bits.
   always_comb begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         diff[k] = $signed({din[k*WIDTH + WIDTH - 1], din[k*WIDTH +: WIDTH]})
                 - $signed({prev[k][WIDTH-1], prev[k]});
         mag[k]  = diff[k][WIDTH] ? WIDTH'(-diff[k]) : diff[k][WIDTH-1:0];
      end
      fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         primed   <= 1'b0;
         s1_valid <= 1'b0;
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            prev[k]  <= '0;
            mag_q[k] <= '0;
         end
      end else begin
         s1_valid <= in_valid && primed;
         if (in_valid) begin
            primed <= 1'b1;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
               prev[k] <= din[k*WIDTH +: WIDTH];
               if (primed) mag_q[k] <= mag[k];
            end
         end
      end
   end

   // Buffer starts zeroed, so subtracting the evicted entry is exact while the window fills.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         fill     <= '0;
         s2_valid <= 1'b0;
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            sum[k] <= '0;
            for (int unsigned j = 0; j < WIN_LEN; j++) win_buf[k][j] <= '0;
         end
      end else begin
         s2_valid <= s1_valid && (fill_next == FILL_MAX);
         if (s1_valid) begin
            wptr <= wptr + 1'b1;
            fill <= fill_next;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
               sum[k]           <= sum[k] + SUM_W'(mag_q[k]) - SUM_W'(win_buf[k][wptr]);
               win_buf[k][wptr] <= mag_q[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         ll_out    <= '0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
`ifdef LL_NORM_EN
               ll_out[k*SUM_W +: SUM_W] <= sum[k] >> LOG2_WIN;
`else
               ll_out[k*SUM_W +: SUM_W] <= sum[k];
`endif
            end
         end
      end
   end

   assign win_full = (fill == FILL_MAX);

endmodule
